// File: rtl/motor_pwm_ctrl_pkg.sv
// rtl/motor_pwm_ctrl_pkg.sv - steering command encodings and H-bridge direction codes
package motor_pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        STOP        = 2'b00,
        TURN_RIGHT  = 2'b01,
        TURN_LEFT   = 2'b10,
        GO_STRAIGHT = 2'b11
    } steer_e;

    localparam logic [1:0] DIR_FWD   = 2'b10;
    localparam logic [1:0] DIR_COAST = 2'b00;

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - per-wheel duty ramp, period-aligned duty latch, PWM compare and direction
module pwm_channel #(
    parameter int PWM_BITS  = 10,
    parameter int RAMP_STEP = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic [PWM_BITS-1:0] target_in,
    output logic                pwm,
    output logic [1:0]          dir,
    output logic                done
);
    import motor_pwm_ctrl_pkg::*;

    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(RAMP_STEP);

    logic [PWM_BITS-1:0] cur;
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] applied;
    logic [PWM_BITS-1:0] headroom;

    // Only meaningful when cur < target_in, so it never underflows where used.
    assign headroom = target_in - cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur     <= '0;
            target  <= '0;
            applied <= '0;
            pwm     <= 1'b0;
            dir     <= DIR_COAST;
        end else begin
            target <= target_in;
            // Deceleration is immediate; acceleration waits for ramp ticks and saturates at target.
            if (cur > target_in) begin
                cur <= target_in;
            end else if (tick && (cur < target_in)) begin
                cur <= (headroom <= STEP) ? target_in : cur + STEP;
            end
            if (wrap) begin
                applied <= cur;
            end
            pwm <= (cnt < applied);
            dir <= (cur != '0) ? DIR_FWD : DIR_COAST;
        end
    end

    assign done = (cur == target);

endmodule

// File: rtl/motor_pwm_ctrl.sv
// rtl/motor_pwm_ctrl.sv - two-wheel ramped PWM motor driver with shared counter and ramp divider
module motor_pwm_ctrl #(
    parameter int PWM_BITS  = 10,
    parameter int DUTY_FAST = 768,
    parameter int DUTY_SLOW = 384,
    parameter int RAMP_DIV  = 100000,
    parameter int RAMP_STEP = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] state,
    input  logic       start_move,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic [1:0] left_dir,
    output logic [1:0] right_dir,
    output logic       ramp_done
);
    import motor_pwm_ctrl_pkg::*;

    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] FAST = PWM_BITS'(DUTY_FAST);
    localparam logic [PWM_BITS-1:0] SLOW = PWM_BITS'(DUTY_SLOW);

    logic [PWM_BITS-1:0] cnt;
    logic [DIV_W-1:0]    div;
    logic                tick;
    logic                wrap;
    logic [PWM_BITS-1:0] left_target;
    logic [PWM_BITS-1:0] right_target;
    logic                left_done;
    logic                right_done;
    steer_e              cmd;

    assign tick = (div == DIV_W'(RAMP_DIV - 1));
    assign wrap = (cnt == '1);
    assign cmd  = steer_e'(state);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            div <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            div <= tick ? '0 : div + 1'b1;
        end
    end

    always_comb begin
        left_target  = '0;
        right_target = '0;
        if (start_move) begin
            unique case (cmd)
                GO_STRAIGHT: begin left_target = FAST; right_target = FAST; end
                TURN_LEFT:   begin left_target = SLOW; right_target = FAST; end
                TURN_RIGHT:  begin left_target = FAST; right_target = SLOW; end
                STOP:        begin left_target = '0;   right_target = '0;   end
            endcase
        end
    end

    pwm_channel #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_left (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .wrap      (wrap),
        .cnt       (cnt),
        .target_in (left_target),
        .pwm       (left_pwm),
        .dir       (left_dir),
        .done      (left_done)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_right (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .wrap      (wrap),
        .cnt       (cnt),
        .target_in (right_target),
        .pwm       (right_pwm),
        .dir       (right_dir),
        .done      (right_done)
    );

    assign ramp_done = left_done & right_done;

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// tb/tb_motor_pwm_ctrl.sv - directed self-checking bench for motor_pwm_ctrl
module tb_motor_pwm_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] state;
    logic       start_move;
    logic       left_pwm;
    logic       right_pwm;
    logic [1:0] left_dir;
    logic [1:0] right_dir;
    logic       ramp_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int highs = 0;

    motor_pwm_ctrl #(
        .PWM_BITS  (4),
        .DUTY_FAST (12),
        .DUTY_SLOW (6),
        .RAMP_DIV  (4),
        .RAMP_STEP (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .state      (state),
        .start_move (start_move),
        .left_pwm   (left_pwm),
        .right_pwm  (right_pwm),
        .left_dir   (left_dir),
        .right_dir  (right_dir),
        .ramp_done  (ramp_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        reset_n    = 1'b0;
        state      = 2'b11;
        start_move = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_left_pwm",  left_pwm,  0);
        check("rst_right_pwm", right_pwm, 0);
        check("rst_left_dir",  left_dir,  0);
        check("rst_right_dir", right_dir, 0);
        check("rst_ramp_done", ramp_done, 1);
        check("rst_left_cur",  dut.u_left.cur, 0);

        // Ramp from 0 straight ahead: ticks fall on cycles 4, 8, 12.
        reset_n = 1'b1;
        cyc     = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            check("ramp_left_cur",  dut.u_left.cur,  (cyc >= 12) ? 12 : (cyc / 4) * 4);
            check("ramp_right_cur", dut.u_right.cur, (cyc >= 12) ? 12 : (cyc / 4) * 4);
            check("ramp_done_rise", ramp_done, (cyc >= 12) ? 1 : 0);
            check("ramp_pwm_idle",  left_pwm, 0);
        end
        check("ramp_left_dir",  left_dir,  2'b10);
        check("ramp_right_dir", right_dir, 2'b10);

        for (int i = 17; i <= 32; i++) begin
            step();
            check("steady_left_pwm", left_pwm, (((cyc - 1) % 16) < 12) ? 1 : 0);
            if (left_pwm) highs++;
        end
        check("steady_high_count", highs, 12);

        // Turn left mid-period: left drops instantly, applied waits for wrap.
        step_to(36);
        state = 2'b10;
        step();
        check("turn_left_cur",     dut.u_left.cur,     6);
        check("turn_right_cur",    dut.u_right.cur,    12);
        check("turn_left_applied", dut.u_left.applied, 12);
        check("turn_ramp_done",    ramp_done,          1);
        while (cyc < 64) begin
            step();
            check("turn_left_pwm",  left_pwm,  (((cyc - 1) % 16) < ((cyc <= 48) ? 12 : 6)) ? 1 : 0);
            check("turn_right_pwm", right_pwm, (((cyc - 1) % 16) < 12) ? 1 : 0);
            if (cyc == 47) check("turn_applied_hold", dut.u_left.applied, 12);
            if (cyc == 48) check("turn_applied_load", dut.u_left.applied, 6);
        end

        // Stop mid-period: current zero next clock, current period completes.
        step_to(68);
        state = 2'b00;
        step();
        check("stop_left_cur",  dut.u_left.cur,  0);
        check("stop_right_cur", dut.u_right.cur, 0);
        check("stop_dir_lag",   left_dir,        2'b10);
        check("stop_ramp_done", ramp_done,       1);
        step();
        check("stop_left_dir",  left_dir,  2'b00);
        check("stop_right_dir", right_dir, 2'b00);
        while (cyc < 96) begin
            step();
            check("stop_left_pwm",  left_pwm,  (cyc <= 80 && ((cyc - 1) % 16) < 6)  ? 1 : 0);
            check("stop_right_pwm", right_pwm, (cyc <= 80 && ((cyc - 1) % 16) < 12) ? 1 : 0);
        end

        // Global enable drop while ramping straight.
        state = 2'b11;
        step_to(104);
        check("en_ramp_cur", dut.u_left.cur, 8);
        step();
        start_move = 1'b0;
        step();
        check("en_off_left_cur",  dut.u_left.cur,  0);
        check("en_off_right_cur", dut.u_right.cur, 0);
        check("en_off_done",      ramp_done,       1);
        while (cyc < 128) begin
            step();
            check("en_off_left_pwm",  left_pwm,  0);
            check("en_off_right_pwm", right_pwm, 0);
            if (cyc == 107) check("en_off_dir", left_dir, 2'b00);
        end
        start_move = 1'b1;
        step_to(131);
        check("en_on_cur_wait", dut.u_left.cur, 0);
        step();
        check("en_on_cur_4", dut.u_left.cur, 4);
        step_to(136);
        check("en_on_cur_8", dut.u_right.cur, 8);
        step();

        // Asynchronous reset mid-ramp, then ramp restarts from zero.
        reset_n = 1'b0;
        #1;
        check("arst_left_dir",  left_dir,       2'b00);
        check("arst_right_dir", right_dir,      2'b00);
        check("arst_done",      ramp_done,      1);
        check("arst_cur",       dut.u_left.cur, 0);
        check("arst_pwm",       left_pwm,       0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("arst_hold_dir", left_dir, 2'b00);
        reset_n = 1'b1;
        cyc     = 0;
        step_to(3);
        check("rel_cur_wait",  dut.u_left.cur, 0);
        check("rel_done_low",  ramp_done,      0);
        step();
        check("rel_left_cur",  dut.u_left.cur,  4);
        check("rel_right_cur", dut.u_right.cur, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
